// File: rtl/uart_cmd_decoder.sv
// Turns a UART received-byte stream into 2048 move commands: WASD/HJKL letters, R, and
// VT100 arrow escape sequences, delivered one at a time over a valid/ready slot.
module uart_cmd_decoder #(
    parameter int unsigned ESC_TIMEOUT = 100000,
    parameter int unsigned TMR_W       = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    input  logic       i_cmd_ready,
    output logic       o_cmd_valid,
    output logic [2:0] o_cmd,
    output logic       o_overrun,
    output logic       o_err
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StEsc  = 2'd1;
    localparam logic [1:0] StCsi  = 2'd2;

    localparam logic [2:0] CmdUp      = 3'd0;
    localparam logic [2:0] CmdDown    = 3'd1;
    localparam logic [2:0] CmdLeft    = 3'd2;
    localparam logic [2:0] CmdRight   = 3'd3;
    localparam logic [2:0] CmdRestart = 3'd4;

    localparam logic [7:0] ChEsc = 8'h1B;
    localparam logic [TMR_W-1:0] TimeoutLast = TMR_W'(ESC_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TimerMax    = {TMR_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [2:0]       cmd_q, cmd_d;
    logic             overrun_q, overrun_d;
    logic             err_q, err_d;

    logic             emit;
    logic [2:0]       emit_cmd;
    logic             bad_byte;
    logic             accept;

    // Parser: advances on received bytes; a byte always wins over the timeout.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        emit     = 1'b0;
        emit_cmd = CmdUp;
        bad_byte = 1'b0;

        if (i_rx_valid) begin
            case (state_q)
                StEsc: begin
                    timer_d = '0;
                    if (i_rx_data == 8'h5B || i_rx_data == 8'h4F) begin
                        state_d = StCsi;
                    end else if (i_rx_data == ChEsc) begin
                        state_d = StEsc;
                    end else begin
                        bad_byte = 1'b1;
                        state_d  = StIdle;
                    end
                end
                StCsi: begin
                    timer_d = '0;
                    case (i_rx_data)
                        8'h41: begin emit = 1'b1; emit_cmd = CmdUp;    state_d = StIdle; end
                        8'h42: begin emit = 1'b1; emit_cmd = CmdDown;  state_d = StIdle; end
                        8'h43: begin emit = 1'b1; emit_cmd = CmdRight; state_d = StIdle; end
                        8'h44: begin emit = 1'b1; emit_cmd = CmdLeft;  state_d = StIdle; end
                        ChEsc: state_d = StEsc;
                        default: begin
                            if (i_rx_data >= 8'h30 && i_rx_data <= 8'h3F) begin
                                state_d = StCsi;
                            end else if (i_rx_data >= 8'h40 && i_rx_data <= 8'h7E) begin
                                // Well-formed but unsupported sequence: drop quietly.
                                state_d = StIdle;
                            end else begin
                                bad_byte = 1'b1;
                                state_d  = StIdle;
                            end
                        end
                    endcase
                end
                default: begin
                    case (i_rx_data)
                        8'h77, 8'h57, 8'h6B: begin emit = 1'b1; emit_cmd = CmdUp;      end
                        8'h73, 8'h53, 8'h6A: begin emit = 1'b1; emit_cmd = CmdDown;    end
                        8'h61, 8'h41, 8'h68: begin emit = 1'b1; emit_cmd = CmdLeft;    end
                        8'h64, 8'h44, 8'h6C: begin emit = 1'b1; emit_cmd = CmdRight;   end
                        8'h72, 8'h52:        begin emit = 1'b1; emit_cmd = CmdRestart; end
                        ChEsc: begin
                            state_d = StEsc;
                            timer_d = '0;
                        end
                        8'h0D, 8'h0A, 8'h20: ;
                        default: bad_byte = 1'b1;
                    endcase
                end
            endcase
        end else if (state_q != StIdle) begin
            if (timer_q == TimeoutLast) begin
                state_d = StIdle;
            end else if (timer_q != TimerMax) begin
                timer_d = timer_q + 1'b1;
            end
        end

        if (state_d == StIdle) begin
            timer_d = '0;
        end
    end

    // Single-entry output slot; an accept on the same cycle frees room for a new emit.
    always_comb begin
        accept      = cmd_valid_q & i_cmd_ready;
        cmd_valid_d = cmd_valid_q & ~accept;
        cmd_d       = cmd_q;
        overrun_d   = 1'b0;
        err_d       = bad_byte;

        if (emit) begin
            if (!cmd_valid_q || i_cmd_ready) begin
                cmd_valid_d = 1'b1;
                cmd_d       = emit_cmd;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CmdUp;
            overrun_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            overrun_q   <= overrun_d;
            err_q       <= err_d;
        end
    end

    assign o_cmd_valid = cmd_valid_q;
    assign o_cmd       = cmd_q;
    assign o_overrun   = overrun_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: letters, escape sequences, timeout, overrun, reset.
module tb_uart_cmd_decoder;

    localparam int unsigned T = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       overrun;
    logic       err;

    int checks = 0;
    int errors = 0;

    uart_cmd_decoder #(
        .ESC_TIMEOUT(T),
        .TMR_W      (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .i_cmd_ready(cmd_ready),
        .o_cmd_valid(cmd_valid),
        .o_cmd      (cmd),
        .o_overrun  (overrun),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    // Called at a negedge: byte is sampled on the next posedge; returns at the following
    // negedge, where the registered outputs for that byte are visible.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if ({cmd_valid, cmd, overrun, err} !== 6'b0) begin
            $display("FAIL reset_outputs got v=%b c=%0d o=%b e=%b want all 0",
                     cmd_valid, cmd, overrun, err);
            errors++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_letters();
        cmd_ready = 1'b1;
        send_byte(8'h77);
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd0) begin
            $display("FAIL letter_w got v=%b c=%0d want v=1 c=0", cmd_valid, cmd);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            $display("FAIL letter_w_clear got v=%b want 0", cmd_valid);
            errors++;
        end
        send_byte(8'h52);
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd4) begin
            $display("FAIL letter_R got v=%b c=%0d want v=1 c=4", cmd_valid, cmd);
            errors++;
        end
        @(negedge clk);
        send_byte(8'h0D);
        checks++;
        if (cmd_valid !== 1'b0 || err !== 1'b0) begin
            $display("FAIL cr_ignored got v=%b e=%b want 0 0", cmd_valid, err);
            errors++;
        end
    endtask

    task automatic test_csi_arrow();
        cmd_ready = 1'b1;
        send_byte(8'h1B);
        send_byte(8'h5B);
        checks++;
        if (cmd_valid !== 1'b0 || err !== 1'b0) begin
            $display("FAIL csi_partial got v=%b e=%b want 0 0", cmd_valid, err);
            errors++;
        end
        send_byte(8'h44);
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd2) begin
            $display("FAIL csi_left got v=%b c=%0d want v=1 c=2", cmd_valid, cmd);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            $display("FAIL csi_left_once got v=%b want 0", cmd_valid);
            errors++;
        end
        // SS3 form: ESC O A -> UP
        send_byte(8'h1B);
        send_byte(8'h4F);
        send_byte(8'h41);
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd0) begin
            $display("FAIL ss3_up got v=%b c=%0d want v=1 c=0", cmd_valid, cmd);
            errors++;
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic saw_err;
        cmd_ready = 1'b1;
        saw_err = 1'b0;
        // T idle cycles after ESC: sequence abandoned, 'A' decodes as a plain letter.
        send_byte(8'h1B);
        repeat (T) begin
            @(negedge clk);
            saw_err |= err;
        end
        send_byte(8'h41);
        saw_err |= err;
        checks++;
        if (saw_err !== 1'b0) begin
            $display("FAIL timeout_no_err got err seen=%b want 0", saw_err);
            errors++;
        end
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd2) begin
            $display("FAIL timeout_A_left got v=%b c=%0d want v=1 c=2", cmd_valid, cmd);
            errors++;
        end
        @(negedge clk);
        // Byte on the firing cycle wins: '[' still seen in ESC, then 'A' is UP.
        send_byte(8'h1B);
        repeat (T - 1) @(negedge clk);
        send_byte(8'h5B);
        checks++;
        if (err !== 1'b0) begin
            $display("FAIL timeout_edge_err got e=%b want 0", err);
            errors++;
        end
        send_byte(8'h41);
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd0) begin
            $display("FAIL timeout_edge_up got v=%b c=%0d want v=1 c=0", cmd_valid, cmd);
            errors++;
        end
        @(negedge clk);
    endtask

    task automatic test_overrun();
        cmd_ready = 1'b0;
        send_byte(8'h64);
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd3 || overrun !== 1'b0) begin
            $display("FAIL ovr_first got v=%b c=%0d o=%b want 1 3 0", cmd_valid, cmd, overrun);
            errors++;
        end
        send_byte(8'h73);
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd3 || overrun !== 1'b1 || err !== 1'b0) begin
            $display("FAIL ovr_pulse got v=%b c=%0d o=%b e=%b want 1 3 1 0",
                     cmd_valid, cmd, overrun, err);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0 || cmd !== 3'd3) begin
            $display("FAIL ovr_one_cycle got o=%b c=%0d want 0 3", overrun, cmd);
            errors++;
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            $display("FAIL ovr_single_accept got v=%b want 0", cmd_valid);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        cmd_ready = 1'b1;
        send_byte(8'h77);
        send_byte(8'h61);
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd2 || overrun !== 1'b0) begin
            $display("FAIL b2b_reload got v=%b c=%0d o=%b want 1 2 0", cmd_valid, cmd, overrun);
            errors++;
        end
        @(negedge clk);
    endtask

    task automatic test_params_and_err();
        cmd_ready = 1'b1;
        send_byte(8'h1B);
        send_byte(8'h5B);
        send_byte(8'h31);
        send_byte(8'h3B);
        send_byte(8'h35);
        send_byte(8'h43);
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd3 || err !== 1'b0) begin
            $display("FAIL csi_param_right got v=%b c=%0d e=%b want 1 3 0", cmd_valid, cmd, err);
            errors++;
        end
        send_byte(8'h7A);
        checks++;
        if (err !== 1'b1 || cmd_valid !== 1'b0) begin
            $display("FAIL z_err got e=%b v=%b want 1 0", err, cmd_valid);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            $display("FAIL err_one_cycle got e=%b want 0", err);
            errors++;
        end
        // Unsupported final byte: ESC [ 2 ~ is dropped silently.
        send_byte(8'h1B);
        send_byte(8'h5B);
        send_byte(8'h32);
        send_byte(8'h7E);
        checks++;
        if (err !== 1'b0 || cmd_valid !== 1'b0) begin
            $display("FAIL csi_tilde got e=%b v=%b want 0 0", err, cmd_valid);
            errors++;
        end
        // ESC followed by a non-introducer is malformed; the byte is not re-decoded.
        send_byte(8'h1B);
        send_byte(8'h77);
        checks++;
        if (err !== 1'b1 || cmd_valid !== 1'b0) begin
            $display("FAIL esc_bad got e=%b v=%b want 1 0", err, cmd_valid);
            errors++;
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        cmd_ready = 1'b0;
        send_byte(8'h72);
        send_byte(8'h1B);
        send_byte(8'h5B);
        checks++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd4) begin
            $display("FAIL pre_reset_r got v=%b c=%0d want 1 4", cmd_valid, cmd);
            errors++;
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({cmd_valid, cmd, overrun, err} !== 6'b0) begin
            $display("FAIL async_reset got v=%b c=%0d o=%b e=%b want all 0",
                     cmd_valid, cmd, overrun, err);
            errors++;
        end
        @(negedge clk);
        rst = 1'b1;
        cmd_ready = 1'b1;
        @(negedge clk);
        send_byte(8'h43);
        checks++;
        if (err !== 1'b1 || cmd_valid !== 1'b0) begin
            $display("FAIL post_reset_C got e=%b v=%b want 1 0", err, cmd_valid);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_letters();
        test_csi_arrow();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_params_and_err();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
